// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, FSM state encodings and queue entry type for the fetch front end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;
  localparam logic [PC_W-1:0] PC_STEP = 64'd4;

  typedef logic [1:0] state_t;
  localparam state_t ST_FETCH   = 2'd0;
  localparam state_t ST_WAIT    = 2'd1;
  localparam state_t ST_DISCARD = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO of {pc, instr}; flush beats push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, single-outstanding imem handshake, prefetch queue and redirect handling.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] PC_RESET = 64'h0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_en,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t          state;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] pc_next;
  logic            ack;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after;
  logic            empty;
  logic            full;
  entry_t          push_data;
  entry_t          head;

  assign ack         = imem_req && imem_ack;
  assign pop         = out_valid && !stall;
  assign push        = (state == ST_WAIT) && ack && !redirect_en;
  assign pc_next     = fetch_pc + PC_STEP;
  assign count_after = count + CW'(push) - CW'(pop);
  assign push_data   = '{pc: fetch_pc, instr: imem_rdata};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_en),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_FETCH;
      fetch_pc  <= PC_RESET;
      imem_req  <= 1'b0;
      imem_addr <= PC_RESET;
    end else begin
      case (state)
        ST_FETCH: begin
          if (redirect_en) begin
            fetch_pc <= redirect_pc;
          end else if (!full) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_en) begin
            // The handshake cannot be cancelled, so a pending wrong-path reply is drained in DISCARD.
            fetch_pc <= redirect_pc;
            if (ack) begin
              imem_req <= 1'b0;
              state    <= ST_FETCH;
            end else begin
              state <= ST_DISCARD;
            end
          end else if (ack) begin
            fetch_pc <= pc_next;
            if (count_after < CW'(DEPTH)) begin
              imem_addr <= pc_next;
            end else begin
              imem_req <= 1'b0;
              state    <= ST_FETCH;
            end
          end
        end
        ST_DISCARD: begin
          if (redirect_en) fetch_pc <= redirect_pc;
          if (ack) begin
            imem_req <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= ST_FETCH;
        end
      endcase
    end
  end

  assign out_valid = !empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_en = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  logic        reset_w = 1'b1;
  logic        imem_req_w;
  logic [63:0] imem_addr_w;
  logic        imem_ack_w;
  logic [31:0] imem_rdata_w;
  logic        redirect_en_w = 1'b0;
  logic [63:0] redirect_pc_w = 64'h0;
  logic        stall_w = 1'b0;
  logic        out_valid_w;
  logic [31:0] out_instr_w;
  logic [63:0] out_pc_w;

  logic [3:0]  lat = 4'd0;
  logic [3:0]  wcnt;
  logic        pend;
  logic [63:0] pend_addr;
  logic [63:0] acc[$];
  logic [63:0] issued[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] rom(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  fetch_unit #(.DEPTH(4), .PC_RESET(64'h0)) u_dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .stall(stall), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_unit #(.DEPTH(4), .PC_RESET(64'hFFFF_FFFF_FFFF_FFF8)) u_wrap (
    .clock(clock), .reset(reset_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w), .redirect_en(redirect_en_w),
    .redirect_pc(redirect_pc_w), .stall(stall_w), .out_valid(out_valid_w),
    .out_instr(out_instr_w), .out_pc(out_pc_w)
  );

  // Memory model: ack after lat idle cycles of an outstanding request.
  assign imem_ack     = imem_req && (wcnt >= lat);
  assign imem_rdata   = rom(imem_addr);
  assign imem_ack_w   = imem_req_w;
  assign imem_rdata_w = rom(imem_addr_w);

  always @(posedge clock) begin
    if (reset || !imem_req || imem_ack) wcnt <= 4'd0;
    else wcnt <= wcnt + 4'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid) check("instr", 64'(out_instr), 64'(rom(out_pc)));
      if (out_valid && !stall) acc.push_back(out_pc);
      if (imem_req && imem_ack) issued.push_back(imem_addr);
      if (pend && imem_req) check("addr_stable", imem_addr, pend_addr);
    end
    if (!reset_w && out_valid_w) check("instr_w", 64'(out_instr_w), 64'(rom(out_pc_w)));
    pend      <= !reset && imem_req && !imem_ack;
    pend_addr <= imem_addr;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic restart();
    reset = 1'b1;
    step(2);
    acc.delete();
    issued.delete();
    reset = 1'b0;
  endtask

  task automatic wait_req(input logic [63:0] a, input bit eq, input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (imem_req && ((imem_addr == a) == eq)) ok = 1'b1;
      else step(1);
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    logic [63:0] exp_w [4];
    int          mark;
    bit          seen;
    exp_w = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};

    // 1: reset state and zero-wait streaming
    step(2);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", imem_addr, 64'h0);
    restart();
    step(1);
    check("t1_req", 64'(imem_req), 64'd1);
    check("t1_addr0", imem_addr, 64'h0);
    check("t1_valid0", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_pc", out_pc, 64'(4 * i));
      check("t1_addr", imem_addr, 64'(4 * (i + 1)));
    end

    // 2: stall fills the queue then holds
    stall = 1'b1;
    restart();
    step(10);
    check("t2_fetches", 64'(issued.size()), 64'd4);
    check("t2_req", 64'(imem_req), 64'd0);
    check("t2_pc_hold", out_pc, 64'h0);
    check("t2_acc", 64'(acc.size()), 64'd0);
    stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("t2_valid", 64'(out_valid), 64'd1);
      check("t2_pc", out_pc, 64'(4 * i));
    end

    // 3: slow memory, no duplicate or skipped PCs
    lat = 4'd2;
    restart();
    step(30);
    check("t3_count", 64'(acc.size() >= 8 && acc.size() <= 10), 64'd1);
    foreach (acc[i]) check("t3_seq", acc[i], 64'(4 * i));

    // 4: redirect while a request to 0x10 is pending
    restart();
    wait_req(64'h10, 1'b1, "t4_reach_0x10");
    redirect_en = 1'b1;
    redirect_pc = 64'h100;
    step(1);
    redirect_en = 1'b0;
    mark = acc.size();
    check("t4_flush", 64'(out_valid), 64'd0);
    check("t4_req_held", 64'(imem_req), 64'd1);
    check("t4_addr_held", imem_addr, 64'h10);
    wait_req(64'h10, 1'b0, "t4_next_req");
    check("t4_next_addr", imem_addr, 64'h100);
    step(10);
    check("t4_got_more", 64'(acc.size() > mark), 64'd1);
    if (acc.size() > mark) check("t4_first_pc", acc[mark], 64'h100);
    seen = 1'b0;
    foreach (acc[i]) if (acc[i] == 64'h10) seen = 1'b1;
    check("t4_no_0x10", 64'(seen), 64'd0);

    // 5: redirect coincident with ack and stall
    lat = 4'd0;
    stall = 1'b1;
    restart();
    step(3);
    check("t5_pre_req", 64'(imem_req), 64'd1);
    redirect_en = 1'b1;
    redirect_pc = 64'h200;
    step(1);
    redirect_en = 1'b0;
    check("t5_flush", 64'(out_valid), 64'd0);
    check("t5_req_drop", 64'(imem_req), 64'd0);
    step(1);
    check("t5_req", 64'(imem_req), 64'd1);
    check("t5_addr", imem_addr, 64'h200);
    check("t5_empty", 64'(out_valid), 64'd0);
    stall = 1'b0;
    step(1);
    check("t5_valid", 64'(out_valid), 64'd1);
    check("t5_pc", out_pc, 64'h200);

    // 6a: PC wraps modulo 2^64
    reset_w = 1'b0;
    step(2);
    for (int i = 0; i < 4; i++) begin
      check("t6_valid_w", 64'(out_valid_w), 64'd1);
      check("t6_pc_w", out_pc_w, exp_w[i]);
      step(1);
    end

    // 6b: reset asserted while a request is outstanding
    lat = 4'd3;
    stall = 1'b1;
    restart();
    step(10);
    check("t6_pre_req", 64'(imem_req), 64'd1);
    check("t6_pre_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    step(1);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_req", 64'(imem_req), 64'd0);
    check("t6_rst_addr", imem_addr, 64'h0);
    reset = 1'b0;
    step(1);
    check("t6_restart_req", 64'(imem_req), 64'd1);
    check("t6_restart_addr", imem_addr, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
    $fatal(1);
  end

endmodule
